// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the programmable IO timer.
package timer_pkg;
  localparam int unsigned PRESCALE_DEFAULT = 24999;  // 25000 cycles = 1 ms at 25 MHz

  typedef enum logic { ST_IDLE, ST_RUN } state_t;
  typedef enum logic { MODE_ONESHOT, MODE_PERIODIC } mode_t;
endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: ticks for one cycle whenever its counter sits at 0 while enabled,
// then reloads with the period captured at the last load.
module timer_prescaler #(
  parameter int PRESCALE_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] load_val,
  input  logic                  enable,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] period;

  assign tick = enable && (cnt == '0);

  // Period is latched on load so later register writes wait for the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      period <= '0;
    end else if (load) begin
      cnt    <= load_val;
      period <= load_val;
    end else if (enable) begin
      cnt <= (cnt == '0) ? period : cnt - 1'b1;
    end
  end
endmodule

// File: rtl/timer_unit.sv
// Programmable down-counting timer: one-shot or auto-reload, prescaled,
// with stop, silent retrigger and live count readback.
module timer_unit
  import timer_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          PRESCALE_W   = 32,
  parameter int unsigned PRESCALE_RST = PRESCALE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value_in,
  input  logic                  set_value,
  input  logic [PRESCALE_W-1:0] prescale_in,
  input  logic                  set_prescale,
  input  logic                  periodic,
  input  logic                  trigger,
  input  logic                  stop,
  output logic                  interrupt,
  output logic                  busy,
  output logic [WIDTH-1:0]      count_out
);
  state_t                state;
  mode_t                 mode;
  logic [WIDTH-1:0]      reload;
  logic [PRESCALE_W-1:0] preg;
  logic [WIDTH-1:0]      count;

  logic                  run_edge;
  logic                  expire;
  logic                  p_load;
  logic [PRESCALE_W-1:0] p_load_val;
  logic                  p_en;
  logic                  p_tick;

  // Trigger bypasses a same-edge register write; periodic reload uses the registers.
  always_comb begin
    run_edge   = !stop && !trigger && (state == ST_RUN);
    expire     = run_edge && (count == '0);
    p_load     = !stop && (trigger || (expire && mode == MODE_PERIODIC));
    p_load_val = (trigger && set_prescale) ? prescale_in : preg;
    p_en       = run_edge && (count != '0);
  end

  timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .load     (p_load),
    .load_val (p_load_val),
    .enable   (p_en),
    .tick     (p_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mode      <= MODE_ONESHOT;
      reload    <= '0;
      preg      <= PRESCALE_W'(PRESCALE_RST);
      count     <= '0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= 1'b0;
      if (set_value)    reload <= value_in;
      if (set_prescale) preg   <= prescale_in;

      if (stop) begin
        state <= ST_IDLE;
      end else if (trigger) begin
        count <= set_value ? value_in : reload;
        mode  <= periodic ? MODE_PERIODIC : MODE_ONESHOT;
        state <= ST_RUN;
      end else if (state == ST_RUN) begin
        if (count == '0) begin
          interrupt <= 1'b1;
          if (mode == MODE_ONESHOT) state <= ST_IDLE;
          else                      count <= reload;
        end else if (p_tick) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  assign busy      = (state == ST_RUN);
  assign count_out = count;
endmodule
